// File: rtl/inst_mem_server.sv
// inst_mem_server: instruction-memory responder for the single-cycle MIPS core.
// After reset it collects a program as a big-endian byte stream and holds the
// core in reset. Once loading finishes it serves fetches combinationally, and
// returns 0 (nop) for words that were never loaded.
module inst_mem_server #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [7:0]       load_byte,
    input  logic             load_last,
    output logic             load_ready,
    input  logic             reload,
    input  logic [31:0]      Inst_address,
    output logic [31:0]      Inst,
    output logic             cpu_rst,
    output logic [IDX_W:0]   loaded_words,
    output logic             overflow,
    output logic             addr_fault
);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH_WORDS);
    localparam logic [IDX_W:0] ONE_WORD   = (IDX_W+1)'(1);

    logic [0:0]       state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      word_q, word_d;
    logic [IDX_W:0]   loaded_words_q, loaded_words_d;
    logic             overflow_q, overflow_d;
    logic             addr_fault_q, addr_fault_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [31:0]      mem_wdata;

    logic             accept;
    logic [31:0]      word_next;
    logic [IDX_W-1:0] fetch_idx;
    logic             fetch_upper_zero;
    logic             fetch_misaligned;

    assign accept           = (state_q == ST_LOAD) && load_valid;
    assign fetch_idx        = Inst_address[IDX_W+1:2];
    assign fetch_upper_zero = (Inst_address[31:IDX_W+2] == '0);
    assign fetch_misaligned = (Inst_address[1:0] != 2'b00);

    // Merge the incoming byte into its lane; lane 0 starts a fresh zeroed word
    // so a short final word carries zeros in its unfilled lower lanes.
    always_comb begin
        word_next = (byte_cnt_q == 2'd0) ? '0 : word_q;
        case (byte_cnt_q)
            2'd0:    word_next[31:24] = load_byte;
            2'd1:    word_next[23:16] = load_byte;
            2'd2:    word_next[15:8]  = load_byte;
            default: word_next[7:0]   = load_byte;
        endcase
    end

    // Next-state logic for the LOAD/RUN controller, byte packer and flags.
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        word_d         = word_q;
        loaded_words_d = loaded_words_q;
        overflow_d     = overflow_q;
        addr_fault_d   = addr_fault_q;
        mem_we         = 1'b0;
        mem_waddr      = loaded_words_q[IDX_W-1:0];
        mem_wdata      = word_next;

        if (state_q == ST_LOAD) begin
            if (accept) begin
                word_d     = word_next;
                byte_cnt_d = byte_cnt_q + 2'd1;
                if ((byte_cnt_q == 2'd3) || load_last) begin
                    mem_we         = 1'b1;
                    loaded_words_d = loaded_words_q + ONE_WORD;
                    byte_cnt_d     = 2'd0;
                    if (load_last) begin
                        state_d = ST_RUN;
                    end else if (loaded_words_q + ONE_WORD == FULL_COUNT) begin
                        overflow_d = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
            end
        end else begin
            if (reload) begin
                state_d        = ST_LOAD;
                loaded_words_d = '0;
                byte_cnt_d     = 2'd0;
                overflow_d     = 1'b0;
                addr_fault_d   = 1'b0;
            end else if (fetch_misaligned || !fetch_upper_zero) begin
                addr_fault_d = 1'b1;
            end
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_LOAD;
            byte_cnt_q     <= 2'd0;
            word_q         <= '0;
            loaded_words_q <= '0;
            overflow_q     <= 1'b0;
            addr_fault_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            loaded_words_q <= loaded_words_d;
            overflow_q     <= overflow_d;
            addr_fault_q   <= addr_fault_d;
        end
    end

    // Instruction array write port; contents are never reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Combinational fetch, gated so stale or unloaded words read as nop.
    always_comb begin
        Inst = '0;
        if ((state_q == ST_RUN) && fetch_upper_zero &&
            ({1'b0, fetch_idx} < loaded_words_q)) begin
            Inst = mem[fetch_idx];
        end
    end

    assign load_ready   = (state_q == ST_LOAD);
    assign cpu_rst      = (state_q != ST_RUN);
    assign loaded_words = loaded_words_q;
    assign overflow     = overflow_q;
    assign addr_fault   = addr_fault_q;

endmodule

// File: tb/tb_inst_mem_server.sv
// Directed testbench for inst_mem_server.
module tb_inst_mem_server;

    logic        clock;
    logic        rst;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic        reload;
    logic [31:0] Inst_address;
    logic [31:0] Inst;
    logic        cpu_rst;
    logic [8:0]  loaded_words;
    logic        overflow;
    logic        addr_fault;

    int checks = 0;
    int errors = 0;

    inst_mem_server #(.DEPTH_WORDS(256), .IDX_W(8)) dut (
        .clock       (clock),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .reload      (reload),
        .Inst_address(Inst_address),
        .Inst        (Inst),
        .cpu_rst     (cpu_rst),
        .loaded_words(loaded_words),
        .overflow    (overflow),
        .addr_fault  (addr_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one byte at the falling edge, return 1 time unit after the rising edge.
    task automatic send_byte(input logic [7:0] b, input logic last);
        @(negedge clock);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        @(posedge clock);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulse_reload();
        @(negedge clock);
        reload = 1'b1;
        @(posedge clock);
        #1;
        reload = 1'b0;
    endtask

    // Set a fetch address between edges and let the combinational path settle.
    task automatic set_addr(input logic [31:0] a);
        @(negedge clock);
        Inst_address = a;
        #1;
    endtask

    task automatic test_power_on();
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL power_on_cpu_rst got %0b exp 1", cpu_rst); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL power_on_load_ready got %0b exp 1", load_ready); end
        checks++; if (loaded_words !== 9'd0) begin errors++; $display("FAIL power_on_loaded got %0d exp 0", loaded_words); end
    endtask

    task automatic test_eight_byte();
        logic [7:0] bytes [8];
        bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        for (int i = 0; i < 7; i++) send_byte(bytes[i], 1'b0);
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL eight_cpu_rst_before got %0b exp 1", cpu_rst); end
        checks++; if (loaded_words !== 9'd1) begin errors++; $display("FAIL eight_loaded_mid got %0d exp 1", loaded_words); end
        send_byte(bytes[7], 1'b1);
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL eight_cpu_rst_after got %0b exp 0", cpu_rst); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL eight_load_ready got %0b exp 0", load_ready); end
        checks++; if (loaded_words !== 9'd2) begin errors++; $display("FAIL eight_loaded got %0d exp 2", loaded_words); end
        set_addr(32'h0);
        checks++; if (Inst !== 32'h20080005) begin errors++; $display("FAIL eight_fetch0 got %h exp 20080005", Inst); end
        set_addr(32'h4);
        checks++; if (Inst !== 32'h01095020) begin errors++; $display("FAIL eight_fetch4 got %h exp 01095020", Inst); end
        set_addr(32'h8);
        checks++; if (Inst !== 32'h0) begin errors++; $display("FAIL eight_fetch8 got %h exp 0", Inst); end
        set_addr(32'h0);
        checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL eight_no_fault got %0b exp 0", addr_fault); end
    endtask

    task automatic test_misaligned();
        set_addr(32'h6);
        checks++; if (Inst !== 32'h01095020) begin errors++; $display("FAIL misaligned_data got %h exp 01095020", Inst); end
        @(posedge clock); #1;
        checks++; if (addr_fault !== 1'b1) begin errors++; $display("FAIL misaligned_fault got %0b exp 1", addr_fault); end
        set_addr(32'h0);
        @(posedge clock); #1;
        checks++; if (addr_fault !== 1'b1) begin errors++; $display("FAIL misaligned_sticky got %0b exp 1", addr_fault); end
    endtask

    task automatic test_reload();
        pulse_reload();
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reload_cpu_rst got %0b exp 1", cpu_rst); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reload_load_ready got %0b exp 1", load_ready); end
        checks++; if (loaded_words !== 9'd0) begin errors++; $display("FAIL reload_loaded got %0d exp 0", loaded_words); end
        checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL reload_fault_clr got %0b exp 0", addr_fault); end
        checks++; if (Inst !== 32'h0) begin errors++; $display("FAIL reload_inst_zero got %h exp 0", Inst); end
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b1);
        checks++; if (loaded_words !== 9'd1) begin errors++; $display("FAIL reload_loaded_new got %0d exp 1", loaded_words); end
        set_addr(32'h0);
        checks++; if (Inst !== 32'hDEADBEEF) begin errors++; $display("FAIL reload_fetch0 got %h exp deadbeef", Inst); end
        set_addr(32'h4);
        checks++; if (Inst !== 32'h0) begin errors++; $display("FAIL reload_stale_hidden got %h exp 0", Inst); end
        set_addr(32'h0);
    endtask

    task automatic test_partial();
        logic [7:0] bytes [6];
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        pulse_reload();
        for (int i = 0; i < 6; i++) send_byte(bytes[i], (i == 5));
        checks++; if (loaded_words !== 9'd2) begin errors++; $display("FAIL partial_loaded got %0d exp 2", loaded_words); end
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL partial_cpu_rst got %0b exp 0", cpu_rst); end
        set_addr(32'h4);
        checks++; if (Inst !== 32'h11220000) begin errors++; $display("FAIL partial_fetch4 got %h exp 11220000", Inst); end
        set_addr(32'h0);
        checks++; if (Inst !== 32'hAABBCCDD) begin errors++; $display("FAIL partial_fetch0 got %h exp aabbccdd", Inst); end
    endtask

    task automatic test_reset();
        set_addr(32'h6);
        @(posedge clock); #1;
        checks++; if (addr_fault !== 1'b1) begin errors++; $display("FAIL reset_pre_fault got %0b exp 1", addr_fault); end
        @(negedge clock);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got %0b exp 1", cpu_rst); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %0b exp 1", load_ready); end
        checks++; if (Inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", Inst); end
        checks++; if (loaded_words !== 9'd0) begin errors++; $display("FAIL reset_loaded got %0d exp 0", loaded_words); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
        checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b exp 0", addr_fault); end
        Inst_address = 32'h0;
        @(negedge clock);
        rst = 1'b1;
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 5; i++) send_byte(8'hF0 + 8'(i), 1'b0);
        checks++; if (loaded_words !== 9'd1) begin errors++; $display("FAIL midload_pre got %0d exp 1", loaded_words); end
        @(negedge clock);
        #2;
        rst = 1'b0;
        #3;
        rst = 1'b1;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b1);
        checks++; if (loaded_words !== 9'd1) begin errors++; $display("FAIL midload_loaded got %0d exp 1", loaded_words); end
        set_addr(32'h0);
        checks++; if (Inst !== 32'h12345678) begin errors++; $display("FAIL midload_fetch0 got %h exp 12345678", Inst); end
        set_addr(32'h4);
        checks++; if (Inst !== 32'h0) begin errors++; $display("FAIL midload_fetch4 got %h exp 0", Inst); end
        set_addr(32'h0);
    endtask

    task automatic test_overflow();
        pulse_reload();
        for (int i = 0; i < 1027; i++) begin
            send_byte(8'(i), 1'b0);
            if (i == 1022) begin
                checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_before got %0b exp 1", load_ready); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_flag_before got %0b exp 0", overflow); end
            end
            if (i == 1023) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
                checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %0b exp 0", load_ready); end
                checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL ovf_run got %0b exp 0", cpu_rst); end
            end
        end
        checks++; if (loaded_words !== 9'd256) begin errors++; $display("FAIL ovf_loaded got %0d exp 256", loaded_words); end
        set_addr(32'h0);
        checks++; if (Inst !== 32'h00010203) begin errors++; $display("FAIL ovf_fetch0 got %h exp 00010203", Inst); end
        set_addr(32'h3FC);
        checks++; if (Inst !== 32'hFCFDFEFF) begin errors++; $display("FAIL ovf_fetch_last got %h exp fcfdfeff", Inst); end
        checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL ovf_fault_before got %0b exp 0", addr_fault); end
        set_addr(32'h400);
        checks++; if (Inst !== 32'h0) begin errors++; $display("FAIL ovf_fetch_oor got %h exp 0", Inst); end
        @(posedge clock); #1;
        checks++; if (addr_fault !== 1'b1) begin errors++; $display("FAIL ovf_fault got %0b exp 1", addr_fault); end
        set_addr(32'h0);
    endtask

    initial begin
        rst          = 1'b0;
        load_valid   = 1'b0;
        load_byte    = 8'h00;
        load_last    = 1'b0;
        reload       = 1'b0;
        Inst_address = 32'h0;
        repeat (2) @(negedge clock);
        rst = 1'b1;
        test_power_on();
        test_eight_byte();
        test_misaligned();
        test_reload();
        test_partial();
        test_reset();
        test_reset_midload();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
